// File: rtl/lc3b_types.sv
// Shared types for the L2 port arbiter: FSM state, grant id, widths and the
// saturating counter helper.
package lc3b_types;

    localparam int LC3B_LINE_W = 128;
    localparam int LC3B_ADDR_W = 16;
    localparam logic [15:0] GRANT_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_RD_BUSY,
        D_WR_BUSY
    } l2_arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } l2_grant_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == GRANT_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// Cache-side and L2-side signal bundle of the arbiter. The slave modport is the
// arbiter's view; master is the surrounding caches plus L2 model.
interface l2_port_arbiter_if
    import lc3b_types::*;
#(
    parameter int ADDR_W = LC3B_ADDR_W,
    parameter int LINE_W = LC3B_LINE_W
);
    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_address;
    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_address;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic              icache_mem_resp;
    logic              dcache_mem_resp;
    logic [LINE_W-1:0] icache_mem_rdata;
    logic [LINE_W-1:0] dcache_mem_rdata;
    logic              l2_pmem_read;
    logic              l2_pmem_write;
    logic [ADDR_W-1:0] l2_pmem_address;
    logic [LINE_W-1:0] l2_pmem_wdata;
    logic              l2_pmem_resp;
    logic [LINE_W-1:0] l2_pmem_rdata;

    modport slave (
        input  icache_pmem_read, icache_pmem_address,
        input  dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        output icache_mem_resp, dcache_mem_resp, icache_mem_rdata, dcache_mem_rdata,
        output l2_pmem_read, l2_pmem_write, l2_pmem_address, l2_pmem_wdata,
        input  l2_pmem_resp, l2_pmem_rdata
    );

    modport master (
        output icache_pmem_read, icache_pmem_address,
        output dcache_pmem_read, dcache_pmem_write, dcache_pmem_address, dcache_pmem_wdata,
        input  icache_mem_resp, dcache_mem_resp, icache_mem_rdata, dcache_mem_rdata,
        input  l2_pmem_read, l2_pmem_write, l2_pmem_address, l2_pmem_wdata,
        output l2_pmem_resp, l2_pmem_rdata
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Registered I/D-cache arbiter for the single L2 port. Contention goes to the
// D-cache unless ARB_ROUND_ROBIN_EN is defined, which alternates grants.
module l2_port_arbiter
    import lc3b_types::*;
(
    input  logic              clk,
    input  logic              reset,
    l2_port_arbiter_if.slave  bus
);

    l2_arb_state_t            state_q;
    logic                     rd_q, wr_q;
    logic [LC3B_ADDR_W-1:0]   addr_q;
    logic [LC3B_LINE_W-1:0]   wdata_q;
    logic [15:0]              i_grant_cnt, d_grant_cnt;
    logic                     i_req, d_req, d_wr, prefer_i, gnt_i, gnt_d;

    assign i_req = bus.icache_pmem_read;
    assign d_wr  = bus.dcache_pmem_write;
    assign d_req = bus.dcache_pmem_read | d_wr;

`ifdef ARB_ROUND_ROBIN_EN
    l2_grant_t last_grant_q;
    assign prefer_i = (last_grant_q == GNT_D);
`else
    assign prefer_i = 1'b0;
`endif

    assign gnt_i = i_req & (~d_req | prefer_i);
    assign gnt_d = d_req & ~gnt_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= GNT_D;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt_i) begin
                        state_q     <= I_BUSY;
                        rd_q        <= 1'b1;
                        wr_q        <= 1'b0;
                        addr_q      <= bus.icache_pmem_address;
                        i_grant_cnt <= sat_inc(i_grant_cnt);
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= GNT_I;
`endif
                    end else if (gnt_d) begin
                        // read+write together is a write-back
                        state_q     <= d_wr ? D_WR_BUSY : D_RD_BUSY;
                        rd_q        <= ~d_wr;
                        wr_q        <= d_wr;
                        addr_q      <= bus.dcache_pmem_address;
                        wdata_q     <= bus.dcache_pmem_wdata;
                        d_grant_cnt <= sat_inc(d_grant_cnt);
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= GNT_D;
`endif
                    end
                end
                default: begin
                    if (bus.l2_pmem_resp) begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.l2_pmem_read     = rd_q;
    assign bus.l2_pmem_write    = wr_q;
    assign bus.l2_pmem_address  = addr_q;
    assign bus.l2_pmem_wdata    = wdata_q;
    assign bus.icache_mem_resp  = (state_q == I_BUSY) & bus.l2_pmem_resp;
    assign bus.dcache_mem_resp  = ((state_q == D_RD_BUSY) | (state_q == D_WR_BUSY)) & bus.l2_pmem_resp;
    assign bus.icache_mem_rdata = bus.l2_pmem_rdata;
    assign bus.dcache_mem_rdata = bus.l2_pmem_rdata;

endmodule
